rsp_sync_fifo: RTL and testbench

Single-clock, parametrised response FIFO: the successor to the dual-clock response FIFO for paths where producer and consumer share one clock. It buffers `DATA_WIDTH`-bit response beats between a producer (push side) and a consumer (pop side) with first-word-fall-through output. It adds occupancy count, programmable almost-full/almost-empty flags, a high-watermark register and a synchronous flush. Push/pop port names and handshake sense match the existing response FIFO, so it drops into the same sockets.

---
 rtl/rsp_sync_fifo_pkg.sv | 23 ++
 rtl/rsp_fifo_ram.sv | 30 +++
 rtl/rsp_sync_fifo.sv | 128 ++++++++++++
 tb/tb_rsp_sync_fifo.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rsp_sync_fifo_pkg.sv
// Shared defaults and helpers for the single-clock response FIFO.
// Holds the default beat width and depth, the pointer-width helper,
// and the encoding of the per-cycle handshake outcome.
package rsp_sync_fifo_pkg;

    // Default response beat width and FIFO depth.
    localparam int RSP_DATA_WIDTH = 128;
    localparam int RSP_FIFO_DEPTH = 16;

    // Pointer width: index bits plus one wrap bit.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Which handshakes fire on a given edge, as {push_fire, pop_fire}.
    typedef enum logic [1:0] {
        FIFO_OP_NONE = 2'b00,
        FIFO_OP_POP  = 2'b01,
        FIFO_OP_PUSH = 2'b10,
        FIFO_OP_BOTH = 2'b11
    } fifo_op_e;

endpackage : rsp_sync_fifo_pkg

// File: rtl/rsp_fifo_ram.sv
// Storage for the response FIFO.
// It has one synchronous write port and one asynchronous read port.
// It is kept separate so that a target-specific RAM macro can replace it.
// The contents are never reset; the FIFO pointers decide which entries are live.
module rsp_fifo_ram
    import rsp_sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = RSP_DATA_WIDTH,
    parameter int DEPTH      = RSP_FIFO_DEPTH
) (
    input  logic                     clk_i,
    input  logic                     wr_en_i,
    input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0]    wr_data_i,
    input  logic [$clog2(DEPTH)-1:0] rd_addr_i,
    output logic [DATA_WIDTH-1:0]    rd_data_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // Write the accepted beat into its slot.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule : rsp_fifo_ram

// File: rtl/rsp_sync_fifo.sv
// Single-clock response FIFO with first-word-fall-through output.
// It provides an occupancy count, almost-full and almost-empty flags,
// a high-watermark register, and a synchronous flush.
// Push and pop handshake names match the dual-clock response FIFO.
module rsp_sync_fifo
    import rsp_sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = RSP_DATA_WIDTH,
    parameter int DEPTH      = RSP_FIFO_DEPTH,
    parameter int AF_THRESH  = DEPTH - 2,
    parameter int AE_THRESH  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   io_flush,
    input  logic                   io_push_valid,
    output logic                   io_push_ready,
    input  logic [DATA_WIDTH-1:0]  io_push_rsp_data,
    input  logic                   io_pop_valid,
    output logic                   io_pop_ready,
    output logic [DATA_WIDTH-1:0]  io_pop_rsp_data,
    output logic [$clog2(DEPTH):0] io_count,
    output logic                   io_almost_full,
    output logic                   io_almost_empty,
    output logic [$clog2(DEPTH):0] io_max_count
);

    localparam int PW = ptr_width(DEPTH);
    localparam int AW = PW - 1;

    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [PW-1:0] AF_LEVEL = PW'(AF_THRESH);
    localparam logic [PW-1:0] AE_LEVEL = PW'(AE_THRESH);
    localparam logic [PW-1:0] FULL_LVL = PW'(DEPTH);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] count_q,  count_d;
    logic [PW-1:0] max_q,    max_d;

    logic     empty;
    logic     full;
    logic     push_fire;
    logic     pop_fire;
    fifo_op_e op;

    // The pointers are equal when the FIFO is empty.
    // When it is full, the index bits match and the wrap bits differ.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                   (wr_ptr_q[AW] != rd_ptr_q[AW]);

    // Push readiness ignores the pop side on purpose.
    // A full FIFO refuses a push even when a pop fires on the same edge.
    assign io_push_ready = ~rst & ~io_flush & ~full;
    assign io_pop_ready  = ~rst & ~empty;

    assign push_fire = io_push_valid & io_push_ready;
    assign pop_fire  = io_pop_valid & io_pop_ready;
    assign op        = fifo_op_e'({push_fire, pop_fire});

    rsp_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_ram (
        .clk_i     (clk),
        .wr_en_i   (push_fire),
        .wr_addr_i (wr_ptr_q[AW-1:0]),
        .wr_data_i (io_push_rsp_data),
        .rd_addr_i (rd_ptr_q[AW-1:0]),
        .rd_data_o (io_pop_rsp_data)
    );

    // Work out the next pointers, occupancy and watermark.
    // Flush overrides any handshake made in the same cycle.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        max_d    = max_q;
        if (io_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            case (op)
                FIFO_OP_PUSH: wr_ptr_d = wr_ptr_q + PTR_ONE;
                FIFO_OP_POP:  rd_ptr_d = rd_ptr_q + PTR_ONE;
                FIFO_OP_BOTH: begin
                    wr_ptr_d = wr_ptr_q + PTR_ONE;
                    rd_ptr_d = rd_ptr_q + PTR_ONE;
                end
                default: ;
            endcase
        end
        count_d = wr_ptr_d - rd_ptr_d;
        if (count_d > max_q) begin
            max_d = count_d;
        end
    end

    // Register the pointer state.
    // Reset clears the watermark too; flush keeps it.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            max_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            max_q    <= max_d;
        end
    end

    assign io_count        = count_q;
    assign io_max_count    = max_q;
    assign io_almost_full  = (count_q >= AF_LEVEL);
    assign io_almost_empty = (count_q <= AE_LEVEL);

    // The occupancy can never exceed the depth.
    // The registered count must always agree with the pointer difference.
    a_count_bound : assert property (@(posedge clk) disable iff (rst)
        count_q <= FULL_LVL);
    a_count_ptrs  : assert property (@(posedge clk) disable iff (rst)
        count_q == (wr_ptr_q - rd_ptr_q));

endmodule : rsp_sync_fifo

// File: tb/tb_rsp_sync_fifo.sv
// Self-checking bench for rsp_sync_fifo.
// The reference model is a queue of beats plus a running maximum.
// One DEPTH=16 instance checks the main behaviour.
// A DEPTH=4 instance checks the thresholds.
module tb_rsp_sync_fifo;

    localparam int DW = 128;
    localparam int DP = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          push_v;
    logic          pop_v;
    logic [DW-1:0] push_d;
    logic          push_rdy;
    logic          pop_rdy;
    logic [DW-1:0] pop_d;
    logic [4:0]    cnt;
    logic          af;
    logic          ae;
    logic [4:0]    maxc;

    logic          t_flush;
    logic          t_push_v;
    logic          t_pop_v;
    logic [7:0]    t_push_d;
    logic          t_push_rdy;
    logic          t_pop_rdy;
    logic [7:0]    t_pop_d;
    logic [2:0]    t_cnt;
    logic          t_af;
    logic          t_ae;
    logic [2:0]    t_maxc;

    logic [DW-1:0] mq[$];
    int            mmax;
    int            errors = 0;
    int            checks = 0;

    always #5 clk = ~clk;

    rsp_sync_fifo #(.DATA_WIDTH(DW), .DEPTH(DP)) u_dut (
        .clk(clk), .rst(rst), .io_flush(flush),
        .io_push_valid(push_v), .io_push_ready(push_rdy), .io_push_rsp_data(push_d),
        .io_pop_valid(pop_v), .io_pop_ready(pop_rdy), .io_pop_rsp_data(pop_d),
        .io_count(cnt), .io_almost_full(af), .io_almost_empty(ae), .io_max_count(maxc)
    );

    rsp_sync_fifo #(.DATA_WIDTH(8), .DEPTH(4), .AF_THRESH(4), .AE_THRESH(1)) u_thr (
        .clk(clk), .rst(rst), .io_flush(t_flush),
        .io_push_valid(t_push_v), .io_push_ready(t_push_rdy), .io_push_rsp_data(t_push_d),
        .io_pop_valid(t_pop_v), .io_pop_ready(t_pop_rdy), .io_pop_rsp_data(t_pop_d),
        .io_count(t_cnt), .io_almost_full(t_af), .io_almost_empty(t_ae), .io_max_count(t_maxc)
    );

    // Advance one edge and apply the FIFO rules to the model.
    // The model sees the inputs that were present at that edge.
    task automatic tick();
        bit push_ok;
        bit pop_ok;
        @(posedge clk);
        push_ok = !rst && !flush && push_v && (mq.size() < DP);
        pop_ok  = !rst && pop_v && (mq.size() > 0);
        if (rst) begin
            mq.delete();
            mmax = 0;
        end else if (flush) begin
            mq.delete();
        end else begin
            if (pop_ok) void'(mq.pop_front());
            if (push_ok) mq.push_back(push_d);
            if (mq.size() > mmax) mmax = mq.size();
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push_v = 1'($urandom_range(1));
            pop_v  = 1'($urandom_range(1));
            push_d = {4{$urandom}};
            #1;
            checks++;
            if (push_rdy !== 1'b0) begin errors++; $display("FAIL reset_push_ready got=%b exp=0", push_rdy); end
            checks++;
            if (pop_rdy !== 1'b0) begin errors++; $display("FAIL reset_pop_ready got=%b exp=0", pop_rdy); end
            tick();
        end
        checks++;
        if (cnt !== 5'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", cnt); end
        checks++;
        if (ae !== 1'b1 || af !== 1'b0) begin errors++; $display("FAIL reset_flags got ae=%b af=%b exp ae=1 af=0", ae, af); end
        checks++;
        if (maxc !== 5'd0) begin errors++; $display("FAIL reset_max got=%0d exp=0", maxc); end
        rst = 1'b0; push_v = 1'b0; pop_v = 1'b0;
        #1;
        checks++;
        if (push_rdy !== 1'b1) begin errors++; $display("FAIL release_push_ready got=%b exp=1", push_rdy); end
        checks++;
        if (pop_rdy !== 1'b0) begin errors++; $display("FAIL release_pop_ready got=%b exp=0", pop_rdy); end
    endtask

    task automatic test_fill_drain();
        for (int i = 1; i <= DP; i++) begin
            push_v = 1'b1; pop_v = 1'b0; push_d = DW'(i);
            tick();
            checks++;
            if (cnt !== 5'(i)) begin errors++; $display("FAIL fill_count got=%0d exp=%0d", cnt, i); end
            checks++;
            if (af !== (i >= DP - 2)) begin errors++; $display("FAIL fill_af at %0d got=%b", i, af); end
            checks++;
            if (push_rdy !== (i < DP)) begin errors++; $display("FAIL fill_push_ready at %0d got=%b", i, push_rdy); end
        end
        push_v = 1'b0;
        for (int i = 1; i <= DP; i++) begin
            pop_v = 1'b1;
            #1;
            checks++;
            if (pop_d !== DW'(i)) begin errors++; $display("FAIL drain_data got=%0h exp=%0h", pop_d, i); end
            tick();
        end
        pop_v = 1'b0;
        checks++;
        if (pop_rdy !== 1'b0 || cnt !== 5'd0) begin errors++; $display("FAIL drain_end got rdy=%b cnt=%0d exp rdy=0 cnt=0", pop_rdy, cnt); end
        checks++;
        if (maxc !== 5'd16) begin errors++; $display("FAIL drain_max got=%0d exp=16", maxc); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            push_v = 1'b1; pop_v = 1'b0; push_d = {4{$urandom}};
            tick();
        end
        for (int i = 0; i < 40; i++) begin
            push_v = 1'b1; pop_v = 1'b1; push_d = {4{$urandom}};
            #1;
            checks++;
            if (pop_d !== mq[0]) begin errors++; $display("FAIL b2b_data cyc=%0d got=%0h exp=%0h", i, pop_d, mq[0]); end
            tick();
            checks++;
            if (cnt !== 5'd8) begin errors++; $display("FAIL b2b_count cyc=%0d got=%0d exp=8", i, cnt); end
        end
        push_v = 1'b0; pop_v = 1'b0;
    endtask

    task automatic test_full_boundary();
        while (mq.size() < DP) begin
            push_v = 1'b1; pop_v = 1'b0; push_d = {4{$urandom}};
            tick();
        end
        push_v = 1'b1; pop_v = 1'b1; push_d = {4{$urandom}};
        #1;
        checks++;
        if (push_rdy !== 1'b0 || pop_rdy !== 1'b1) begin errors++; $display("FAIL full_ready got push=%b pop=%b exp push=0 pop=1", push_rdy, pop_rdy); end
        tick();
        checks++;
        if (cnt !== 5'd15) begin errors++; $display("FAIL full_pop_count got=%0d exp=15", cnt); end
        pop_v = 1'b0;
        #1;
        checks++;
        if (push_rdy !== 1'b1) begin errors++; $display("FAIL full_retry_ready got=%b exp=1", push_rdy); end
        tick();
        checks++;
        if (cnt !== 5'd16) begin errors++; $display("FAIL full_retry_count got=%0d exp=16", cnt); end
        push_v = 1'b0;
    endtask

    task automatic test_flush();
        logic [DW-1:0] lost;
        rst = 1'b1; tick(); rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            push_v = 1'b1; pop_v = 1'b0; push_d = {4{$urandom}};
            tick();
        end
        push_v = 1'b0; pop_v = 1'b1;
        tick(); tick();
        pop_v = 1'b0;
        checks++;
        if (cnt !== 5'd10 || maxc !== 5'd12) begin errors++; $display("FAIL flush_setup got cnt=%0d max=%0d exp 10/12", cnt, maxc); end
        lost = {4{32'hDEAD_BEEF}};
        flush = 1'b1; push_v = 1'b1; push_d = lost;
        #1;
        checks++;
        if (push_rdy !== 1'b0) begin errors++; $display("FAIL flush_push_ready got=%b exp=0", push_rdy); end
        tick();
        flush = 1'b0; push_v = 1'b0;
        checks++;
        if (cnt !== 5'd0 || pop_rdy !== 1'b0) begin errors++; $display("FAIL flush_clear got cnt=%0d rdy=%b exp 0/0", cnt, pop_rdy); end
        checks++;
        if (maxc !== 5'd12) begin errors++; $display("FAIL flush_max got=%0d exp=12", maxc); end
        push_v = 1'b1; push_d = {4{$urandom}};
        tick();
        push_v = 1'b0;
        checks++;
        if (pop_d !== mq[0] || pop_d === lost || cnt !== 5'd1) begin errors++; $display("FAIL flush_after got=%0h cnt=%0d exp=%0h cnt=1", pop_d, cnt, mq[0]); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            push_v = ($urandom_range(99) < 60);
            pop_v  = ($urandom_range(99) < 50);
            flush  = ($urandom_range(99) < 3);
            push_d = {4{$urandom}};
            #1;
            checks++;
            if (push_rdy !== (!flush && mq.size() < DP)) begin errors++; $display("FAIL rnd_push_ready cyc=%0d got=%b", i, push_rdy); end
            checks++;
            if (pop_rdy !== (mq.size() > 0)) begin errors++; $display("FAIL rnd_pop_ready cyc=%0d got=%b", i, pop_rdy); end
            if (mq.size() > 0) begin
                checks++;
                if (pop_d !== mq[0]) begin errors++; $display("FAIL rnd_data cyc=%0d got=%0h exp=%0h", i, pop_d, mq[0]); end
            end
            tick();
            checks++;
            if (cnt !== 5'(mq.size())) begin errors++; $display("FAIL rnd_count cyc=%0d got=%0d exp=%0d", i, cnt, mq.size()); end
            checks++;
            if (af !== (mq.size() >= DP - 2) || ae !== (mq.size() <= 2)) begin errors++; $display("FAIL rnd_flags cyc=%0d got af=%b ae=%b size=%0d", i, af, ae, mq.size()); end
            checks++;
            if (maxc !== 5'(mmax)) begin errors++; $display("FAIL rnd_max cyc=%0d got=%0d exp=%0d", i, maxc, mmax); end
        end
        push_v = 1'b0; pop_v = 1'b0; flush = 1'b0;
    endtask

    task automatic test_thresholds();
        int level = 0;
        for (int step = 0; step <= 8; step++) begin
            checks++;
            if (t_cnt !== 3'(level)) begin errors++; $display("FAIL thr_count got=%0d exp=%0d", t_cnt, level); end
            checks++;
            if (t_ae !== (level <= 1)) begin errors++; $display("FAIL thr_ae at %0d got=%b", level, t_ae); end
            checks++;
            if (t_af !== (level >= 4)) begin errors++; $display("FAIL thr_af at %0d got=%b", level, t_af); end
            t_push_v = (step < 4);
            t_pop_v  = (step >= 4);
            t_push_d = 8'(step);
            @(posedge clk); #1;
            if (step < 4) level++;
            else if (step < 8) level--;
        end
        t_push_v = 1'b0; t_pop_v = 1'b0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; push_v = 1'b0; pop_v = 1'b0; push_d = '0;
        t_flush = 1'b0; t_push_v = 1'b0; t_pop_v = 1'b0; t_push_d = '0;
        mmax = 0;
        test_reset();
        test_fill_drain();
        test_back_to_back();
        test_full_boundary();
        test_flush();
        test_random();
        test_thresholds();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_rsp_sync_fifo
